// File: rtl/rcu_header_pkg.sv
// rtl/rcu_header_pkg.sv - shared router types: port ids, mesh size, allocator state, credit width
package rcu_header;

    localparam int MESH_X = 4;
    localparam int MESH_Y = 4;
    localparam int MESH_Z = 4;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4,
        UP    = 3'd5,
        DOWN  = 3'd6
    } port_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Counter must hold the full depth value, hence one bit beyond clog2.
    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CREDIT_W = credit_w(4);

endpackage

// File: rtl/output_port_allocator_rr_arbiter.sv
// rtl/output_port_allocator_rr_arbiter.sv - combinational round-robin arbiter, one-hot winner
module rr_arbiter #(
    parameter  int N  = 7,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    int p;
    int d;
    int best_d;

    // Winner is the requester with the smallest wrapped distance from ptr.
    always_comb begin
        grant  = '0;
        p      = int'(ptr);
        d      = 0;
        best_d = N;
        for (int i = 0; i < N; i++) begin
            d = (i - p + N) % N;
            if (req[i] && d < best_d) begin
                best_d = d;
                grant  = N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// rtl/output_port_allocator.sv - per-output wormhole allocator with credits and fault gating
module output_port_allocator
    import rcu_header::*;
#(
    parameter  port_t THIS_PORT    = UP,
    parameter  int    NUM_PORTS    = 7,
    parameter  int    CREDIT_DEPTH = 4,
    localparam int    PW           = $clog2(NUM_PORTS),
    localparam int    CW           = credit_w(CREDIT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PORTS-1:0]  req_valid,
    input  port_t [NUM_PORTS-1:0] req_outport,
    input  logic [NUM_PORTS-1:0]  req_tail,
    input  logic                  link_faulty,
    input  logic                  credit_return,
    output logic [NUM_PORTS-1:0]  grant,
    output logic                  locked,
    output logic [PW-1:0]         owner,
    output logic [CW-1:0]         credits,
    output logic                  port_faulty,
    output logic                  credit_err
);

    alloc_state_t         state;
    logic [PW-1:0]        ptr;
    logic [NUM_PORTS-1:0] eligible;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [NUM_PORTS-1:0] owner_onehot;
    logic [PW-1:0]        winner;
    logic [PW-1:0]        next_ptr;
    logic                 transfer;
    logic                 winner_tail;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] && (req_outport[i] == THIS_PORT);
        end
    end

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .req   (eligible),
        .ptr   (ptr),
        .grant (arb_grant)
    );

    assign owner_onehot = NUM_PORTS'(1) << owner;

    // Fault only blocks new packets; an owned packet always drains to its tail.
    always_comb begin
        grant = '0;
        if (!rst && credits != '0) begin
            if (state == IDLE) begin
                if (!port_faulty) grant = arb_grant;
            end else begin
                grant = eligible & owner_onehot;
            end
        end
    end

    always_comb begin
        winner = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) winner = PW'(i);
        end
    end

    assign transfer    = |grant;
    assign winner_tail = |(grant & req_tail);
    assign next_ptr    = (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
    assign locked      = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            credits     <= CW'(CREDIT_DEPTH);
            port_faulty <= 1'b0;
            credit_err  <= 1'b0;
        end else begin
            port_faulty <= link_faulty;
            if (transfer) begin
                if (winner_tail) begin
                    state <= IDLE;
                    ptr   <= next_ptr;
                end else if (state == IDLE) begin
                    state <= LOCKED;
                    owner <= winner;
                end
            end
            case ({transfer, credit_return})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CW'(CREDIT_DEPTH)) credit_err <= 1'b1;
                    else                              credits    <= credits + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// tb/tb_output_port_allocator.sv - scoreboard bench for output_port_allocator
module tb_output_port_allocator;
    import rcu_header::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] req_valid;
    port_t [6:0] req_outport;
    logic [6:0] req_tail;
    logic       link_faulty;
    logic       credit_return;
    logic [6:0] grant;
    logic       locked;
    logic [2:0] owner;
    logic [2:0] credits;
    logic       port_faulty;
    logic       credit_err;

    typedef struct {
        int         tag;
        logic [6:0] grant;
        logic       locked;
        logic [2:0] owner;
        logic [2:0] credits;
        logic       pf;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag      = 0;

    always #5 clk = ~clk;

    output_port_allocator #(.THIS_PORT(UP), .NUM_PORTS(7), .CREDIT_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_outport   (req_outport),
        .req_tail      (req_tail),
        .link_faulty   (link_faulty),
        .credit_return (credit_return),
        .grant         (grant),
        .locked        (locked),
        .owner         (owner),
        .credits       (credits),
        .port_faulty   (port_faulty),
        .credit_err    (credit_err)
    );

    task automatic cmp(input int t, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL vec%0d %s actual=%0h expected=%0h", t, name, act, exp);
        end
    endtask

    task automatic set_inputs(input logic [6:0] v, input logic [6:0] tl, input logic [6:0] up,
                              input logic lf, input logic cr);
        req_valid = v;
        req_tail  = tl;
        for (int i = 0; i < 7; i++) req_outport[i] = up[i] ? UP : LOCAL;
        link_faulty   = lf;
        credit_return = cr;
    endtask

    task automatic drive(input logic [6:0] v, input logic [6:0] tl, input logic [6:0] up,
                         input logic lf, input logic cr);
        @(posedge clk);
        #1;
        set_inputs(v, tl, up, lf, cr);
    endtask

    task automatic expect_now(input logic [6:0] g, input logic l, input logic [2:0] o,
                              input logic [2:0] c, input logic pf, input logic err);
        exp_t e;
        tag++;
        e.tag = tag; e.grant = g; e.locked = l; e.owner = o;
        e.credits = c; e.pf = pf; e.err = err;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        set_inputs('0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares DUT outputs against every queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp(e.tag, "grant", 32'(grant), 32'(e.grant));
                cmp(e.tag, "locked", 32'(locked), 32'(e.locked));
                if (e.locked) cmp(e.tag, "owner", 32'(owner), 32'(e.owner));
                cmp(e.tag, "credits", 32'(credits), 32'(e.credits));
                cmp(e.tag, "port_faulty", 32'(port_faulty), 32'(e.pf));
                cmp(e.tag, "credit_err", 32'(credit_err), 32'(e.err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_inputs('0, '0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        set_inputs(7'b0000100, 7'b0000100, 7'b0000100, 1'b0, 1'b0);
        expect_now(7'b0000000, 0, 0, 4, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_inputs('0, '0, '0, 1'b0, 1'b0);

        // single-flit packet, then pointer moved to 3
        drive(7'b0000100, 7'b0000100, 7'b0000100, 0, 0); expect_now(7'b0000100, 0, 0, 4, 0, 0);
        drive(7'b0000000, 7'b0000000, 7'b0000000, 0, 0); expect_now(7'b0000000, 0, 0, 3, 0, 0);
        drive(7'b0001010, 7'b0001010, 7'b0001010, 0, 0); expect_now(7'b0001000, 0, 0, 3, 0, 0);
        do_reset();

        // round robin 1,3,5 with input 0 routed elsewhere
        drive(7'b0101011, 7'b0101011, 7'b0101010, 0, 1); expect_now(7'b0000010, 0, 0, 4, 0, 0);
        drive(7'b0101011, 7'b0101011, 7'b0101010, 0, 1); expect_now(7'b0001000, 0, 0, 4, 0, 0);
        drive(7'b0101011, 7'b0101011, 7'b0101010, 0, 1); expect_now(7'b0100000, 0, 0, 4, 0, 0);
        drive(7'b0101011, 7'b0101011, 7'b0101010, 0, 1); expect_now(7'b0000010, 0, 0, 4, 0, 0);
        do_reset();

        // wormhole hold by input 2 while input 4 waits
        drive(7'b0010100, 7'b0010000, 7'b0010100, 0, 0); expect_now(7'b0000100, 0, 0, 4, 0, 0);
        drive(7'b0010100, 7'b0010000, 7'b0010100, 0, 0); expect_now(7'b0000100, 1, 2, 3, 0, 0);
        drive(7'b0010000, 7'b0010000, 7'b0010100, 0, 0); expect_now(7'b0000000, 1, 2, 2, 0, 0);
        drive(7'b0010100, 7'b0010100, 7'b0010100, 0, 0); expect_now(7'b0000100, 1, 2, 2, 0, 0);
        drive(7'b0010000, 7'b0010000, 7'b0010000, 0, 0); expect_now(7'b0010000, 0, 0, 1, 0, 0);
        drive(7'b0010000, 7'b0010000, 7'b0010000, 0, 1); expect_now(7'b0000000, 0, 0, 0, 0, 0);
        drive(7'b0010000, 7'b0010000, 7'b0010000, 0, 0); expect_now(7'b0010000, 0, 0, 1, 0, 0);
        do_reset();

        // credit exhaustion: 5-flit packet from input 6
        drive(7'b1000000, 7'b0000000, 7'b1000000, 0, 0); expect_now(7'b1000000, 0, 0, 4, 0, 0);
        drive(7'b1000000, 7'b0000000, 7'b1000000, 0, 0); expect_now(7'b1000000, 1, 6, 3, 0, 0);
        drive(7'b1000000, 7'b0000000, 7'b1000000, 0, 0); expect_now(7'b1000000, 1, 6, 2, 0, 0);
        drive(7'b1000000, 7'b0000000, 7'b1000000, 0, 0); expect_now(7'b1000000, 1, 6, 1, 0, 0);
        drive(7'b1000000, 7'b1000000, 7'b1000000, 0, 1); expect_now(7'b0000000, 1, 6, 0, 0, 0);
        drive(7'b1000000, 7'b1000000, 7'b1000000, 0, 0); expect_now(7'b1000000, 1, 6, 1, 0, 0);
        drive(7'b0000000, 7'b0000000, 7'b0000000, 0, 0); expect_now(7'b0000000, 0, 0, 0, 0, 0);
        do_reset();

        // fault gating in IDLE, then fault during a locked packet
        drive(7'b0000000, 7'b0000000, 7'b0000000, 1, 0); expect_now(7'b0000000, 0, 0, 4, 0, 0);
        drive(7'b0000010, 7'b0000010, 7'b0000010, 1, 0); expect_now(7'b0000000, 0, 0, 4, 1, 0);
        drive(7'b0000010, 7'b0000010, 7'b0000010, 0, 0); expect_now(7'b0000000, 0, 0, 4, 1, 0);
        drive(7'b0000010, 7'b0000010, 7'b0000010, 0, 0); expect_now(7'b0000010, 0, 0, 4, 0, 0);
        drive(7'b0001000, 7'b0000000, 7'b0001000, 0, 0); expect_now(7'b0001000, 0, 0, 3, 0, 0);
        drive(7'b0001000, 7'b0000000, 7'b0001000, 1, 0); expect_now(7'b0001000, 1, 3, 2, 0, 0);
        drive(7'b0001000, 7'b0001000, 7'b0001000, 1, 0); expect_now(7'b0001000, 1, 3, 1, 1, 0);
        drive(7'b0000000, 7'b0000000, 7'b0000000, 1, 0); expect_now(7'b0000000, 0, 0, 0, 1, 0);
        do_reset();

        // credit overflow, then asynchronous reset mid-packet
        drive(7'b0000000, 7'b0000000, 7'b0000000, 0, 1); expect_now(7'b0000000, 0, 0, 4, 0, 0);
        drive(7'b0000000, 7'b0000000, 7'b0000000, 0, 0); expect_now(7'b0000000, 0, 0, 4, 0, 1);
        drive(7'b0100000, 7'b0000000, 7'b0100000, 0, 0); expect_now(7'b0100000, 0, 0, 4, 0, 1);
        drive(7'b0100000, 7'b0000000, 7'b0100000, 0, 0); expect_now(7'b0100000, 1, 5, 3, 0, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_now(7'b0000000, 0, 0, 4, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_inputs('0, '0, '0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port allocator in the 3D mesh router; consumes the `outport` decisions produced by each input port's routing computation unit.
- Arbitrates among input ports requesting this output with round-robin priority and holds the output for a whole wormhole packet, from head flit to tail flit.
- Tracks downstream buffer credits and gates new allocations while the attached vertical link is reported faulty.
- Exports the fault status back to the routing units as their `up_faulty`/`down_faulty` inputs.

Parameters:
- THIS_PORT, UP, port_t: output port this instance serves.
- NUM_PORTS, 7: number of router input ports (LOCAL, NORTH, SOUTH, EAST, WEST, UP, DOWN).
- CREDIT_DEPTH, 4: downstream input-buffer depth in flits (≥1).

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_PORTS  input i holds a flit ready to send.
- req_outport  input  NUM_PORTS x port_t  routed output of input i's current flit.
- req_tail  input  NUM_PORTS  input i's current flit is a tail (a single-flit packet has head = tail).
- link_faulty  input  1  the downstream link of this output is faulty.
- credit_return  input  1  downstream freed one buffer slot.
- grant  output  NUM_PORTS  one-hot; the flit of input i crosses the switch this cycle.
- locked  output  1  the output is owned by an in-flight packet.
- owner  output  $clog2(NUM_PORTS)  index of the owning input; valid when locked=1.
- credits  output  $clog2(CREDIT_DEPTH)+1  current credit count.
- port_faulty  output  1  registered copy of link_faulty, fed to the routing units.
- credit_err  output  1  sticky credit-overflow flag.

Behaviour:
- Reset values (rst=1):
  - state IDLE, round-robin pointer 0, owner 0, locked 0.
  - credits = CREDIT_DEPTH, port_faulty 0, credit_err 0.
  - grant is forced to 0 while rst is high.
- Eligible request: req_valid[i] && req_outport[i]==THIS_PORT.
- grant is combinational in the same cycle as the request; all state updates on the rising clk edge. A transfer is a cycle in which any grant bit is 1.
- IDLE state:
  - If credits>0 and port_faulty==0, grant the first eligible input at or after the pointer, wrapping from NUM_PORTS-1 to 0.
  - Granted flit is a tail: stay IDLE, pointer = winner+1 mod NUM_PORTS.
  - Granted flit is not a tail: go to LOCKED, owner = winner.
- LOCKED state:
  - Only the owner is eligible; grant it when it is eligible and credits>0.
  - port_faulty does NOT block an in-flight packet, so no packet is truncated.
  - Transfer of a tail: go to IDLE, pointer = owner+1 mod NUM_PORTS.
  - Owner not valid: hold, no grant. Requests from other inputs are ignored.
- Credits:
  - Decrement by 1 on a transfer, increment by 1 on credit_return.
  - Both in the same cycle: credits unchanged.
  - credit_return while credits==CREDIT_DEPTH with no transfer: credits saturate and credit_err is set; it clears only on reset.
  - No grant is ever issued at credits==0, so credits never underflow.
- port_faulty: link_faulty registered through one flop, so it has 1-cycle latency; allocation decisions use port_faulty.
- No eligible request: grant=0 and the pointer is unchanged.
- Reset asserted mid-packet: immediate return to IDLE with credits restored. Upstream flushing is the router's responsibility.

Decomposition:
- port_t and the mesh dimension constants come from the shared rcu_header package.
- Add to that package: an alloc_state_t enum (IDLE, LOCKED) and a CREDIT_W localparam helper.
- One natural sub-module, rr_arbiter:
  - combinational; inputs are a request vector and a pointer; output is a one-hot winner.
  - instantiated once here and reusable by the VC allocator.

Test Plan:
- Single-flit packet: reset, THIS_PORT=UP, req_valid=7'b0000100 with outport UP and tail=1 → grant=7'b0000100 the same cycle, credits 4→3, pointer=3, locked stays 0.
- Round-robin fairness: inputs 1, 3 and 5 all request UP with single-flit packets and credit_return every cycle → grants in the order 1, 3, 5, 1, …, and credits hold at 4.
- Wormhole hold: input 2 sends head, body, tail while input 4 also requests → locked=1 with owner=2 for 3 consecutive grants to input 2. Input 4 is granted in the cycle after the tail.
- Credit exhaustion: 5-flit packet with no credit_return → 4 grants, then credits=0 and grant=0. One credit_return → the 5th flit is granted the next cycle.
- Fault gating: link_faulty=1 in IDLE → port_faulty=1 one cycle later and no new grant. link_faulty asserted while LOCKED → the packet completes to its tail.
- Overflow and reset:
  - credit_return at credits=4 → credit_err=1 and credits stay 4.
  - rst pulsed mid-packet → locked=0, credits=4, credit_err=0 immediately, asynchronously.
